keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Scanned-matrix reader for a 4x4 hex keypad on the lab board.
- Drives one active-low row strobe at a time, using the same one-hot-low rotation as the digit-anode scan (1110, 1101, 1011, 0111).
- Samples the active-low column lines once per row.
- Debounces over whole scan frames and reports one stable key as a 4-bit code with a single-cycle valid pulse, for downstream hex display and register logic.

Parameters:
- SCAN_DIV, 50000, clk cycles each row is held active; must be >= 4.
- DEBOUNCE_FRAMES, 8, consecutive identical frames needed to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- col  input  4  column lines, active-low (pulled up); asynchronous to clk.
- row  output  4  row strobes, active-low one-hot.
- key_code  output  4  accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_pressed  output  1  level; high from acceptance until debounced release.

Behaviour:
- Reset (async, rstn=0):
  - row=4'b1110; key_code=0; key_valid=0; key_pressed=0.
  - Dwell counter=0; row_idx=0; state=IDLE; debounce count=0; frame accumulators cleared.
- Input synchronisation: col passes through a 2-flop synchroniser. Only the synchronised value is used.
- Row timing:
  - Dwell counter runs 0..SCAN_DIV-1.
  - The sample strobe fires on count SCAN_DIV-1. On that edge the synchronised col is sampled for the current row_idx.
  - On the same edge row_idx advances (3 wraps to 0) and row rotates.
  - One frame = 4*SCAN_DIV cycles. Frame end = the sample edge of row_idx 3.
- Frame accumulation:
  - Per frame, count pressed keys, saturating at 2 ("many"). A pressed key is a 0 bit of col.
  - Capture the code of the first key found.
  - Accumulators clear at frame end.
- Frame classes: NONE (0 keys), ONE(code) (exactly 1 key), MULTI (>1 key).
- FSM transitions, evaluated only at frame end:
  - IDLE:
    - ONE(c) -> DEBOUNCE; cand=c; cnt=1.
    - If DEBOUNCE_FRAMES==1, go directly to the acceptance action.
    - Otherwise stay in IDLE.
  - DEBOUNCE:
    - ONE(cand) -> cnt+1. When cnt reaches DEBOUNCE_FRAMES: go to HELD, key_code<=cand, key_valid pulse, key_pressed<=1.
    - NONE, MULTI or a different code -> IDLE, cnt=0.
  - HELD:
    - NONE -> RELEASE; cnt=1. If DEBOUNCE_FRAMES==1, go directly to IDLE.
    - ONE or MULTI -> stay. No new pulse; extra or rolled-over keys are ignored.
  - RELEASE:
    - NONE -> cnt+1. When cnt reaches DEBOUNCE_FRAMES: go to IDLE, key_pressed<=0.
    - Any key -> HELD (bounce on release; no new pulse).
- Output timing:
  - key_valid is high for exactly the one cycle after the accepting frame-end edge.
  - key_code holds its value until the next acceptance.
  - All outputs are registered.
- Press-to-valid latency: DEBOUNCE_FRAMES frames after the first clean frame.
- Reset mid-operation aborts any debounce or hold immediately. No pulse is emitted.

Decomposition:
- Shared package keypad_pkg holds:
  - state enum {IDLE, DEBOUNCE, HELD, RELEASE};
  - row strobe constants ROW0..ROW3 = 1110/1101/1011/0111;
  - the frame-class encoding.
- One sub-module, scan_divider, holds the dwell counter, row_idx, row strobe, sample strobe and frame-end strobe.
- Synchroniser, accumulators and FSM stay in keypad_scan.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=3. The bench col model drives a low col bit when the strobed row matches a pressed key.

1. Reset then idle, no keys:
   - row=1110 for cycles 0-3, then 1101, 1011, 0111; back to 1110 at cycle 16.
   - key_valid, key_pressed and key_code stay 0.
2. Hold key (row 2, col 1) steady for 5 frames:
   - Exactly one key_valid pulse, the cycle after the 3rd frame end.
   - key_code=4'h9; key_pressed=1 thereafter.
3. Bouncy press: pattern press 1 frame, none 1 frame, press 2 frames, none -> no key_valid, key_pressed=0.
4. Keys (0,0) and (3,3) held together for 6 frames -> MULTI every frame; no key_valid.
5. Release bounce:
   - After scenario 2, release 2 frames then press 1 frame -> still HELD, no pulse, key_pressed=1.
   - Then release 3 frames -> key_pressed=0.
   - A new press of (0,3) is then accepted with key_code=4'h3.
6. rstn pulsed low during DEBOUNCE (cnt=2):
   - Outputs 0 and row=1110 immediately (async).
   - After release of reset a full 3 clean frames are required before key_valid.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, frame
// classes and the one-hot-low row strobe patterns.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_ONE   = 2'd1,
    FC_MULTI = 2'd2
  } frame_class_e;

  localparam logic [3:0] ROW0 = 4'b1110;
  localparam logic [3:0] ROW1 = 4'b1101;
  localparam logic [3:0] ROW2 = 4'b1011;
  localparam logic [3:0] ROW3 = 4'b0111;

  function automatic logic [3:0] row_strobe(input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = ROW0;
      2'd1:    r = ROW1;
      2'd2:    r = ROW2;
      default: r = ROW3;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] count_low(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Lowest-numbered low column wins, matching the scan order.
  function automatic logic [1:0] first_low(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix lines and accepted-key outputs; master is the scanner side.
interface keypad_scan_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  modport master (
    input  col,
    output row, key_code, key_valid, key_pressed
  );

  modport slave (
    output col,
    input  row, key_code, key_valid, key_pressed
  );
endinterface

// File: rtl/keypad_scan_scan_divider.sv
// Row dwell timer: holds each row strobe SCAN_DIV cycles and flags the
// per-row sample edge and the end-of-frame edge (sample of row 3).
module scan_divider
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  output logic [3:0] row,
  output logic [1:0] row_idx,
  output logic       sample,
  output logic       frame_end
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    row_q, row_d;

  assign sample    = (cnt_q == CW'(SCAN_DIV - 1));
  assign frame_end = sample && (row_idx_q == 2'd3);
  assign row       = row_q;
  assign row_idx   = row_idx_q;

  always_comb begin
    cnt_d     = sample ? '0 : cnt_q + CW'(1);
    row_idx_d = sample ? row_idx_q + 2'd1 : row_idx_q;
    row_d     = row_strobe(row_idx_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      row_idx_q <= 2'd0;
      row_q     <= ROW0;
    end else begin
      cnt_q     <= cnt_d;
      row_idx_q <= row_idx_d;
      row_q     <= row_d;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: synchronises columns, classifies each scan frame
// and debounces press/release over whole frames.
//   state    | meaning
//   IDLE     | no key accepted, waiting for a single-key frame
//   DEBOUNCE | counting consecutive frames of the same single key
//   HELD     | key accepted, waiting for an empty frame
//   RELEASE  | counting consecutive empty frames
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic          clk,
  input  logic          rstn,
  keypad_scan_if.master kp
);

  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [3:0]   row_w;
  logic [1:0]   row_idx;
  logic         sample, frame_end;

  logic [3:0]   col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [1:0]   acc_cnt_q, acc_cnt_d;
  logic [3:0]   acc_code_q, acc_code_d;

  state_e       state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]   cand_q, cand_d;
  logic [3:0]   key_code_q, key_code_d;
  logic         key_valid_q, key_valid_d;
  logic         key_pressed_q, key_pressed_d;

  logic [2:0]   row_keys, tot_keys;
  logic [1:0]   acc_sum;
  logic [3:0]   acc_code_new;
  frame_class_e fclass;

  scan_divider #(.SCAN_DIV(SCAN_DIV)) u_div (
    .clk       (clk),
    .rstn      (rstn),
    .row       (row_w),
    .row_idx   (row_idx),
    .sample    (sample),
    .frame_end (frame_end)
  );

  assign kp.row         = row_w;
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_pressed = key_pressed_q;

  // Frame totals include the row being sampled on this edge.
  always_comb begin
    col_s1_d     = kp.col;
    col_s2_d     = col_s1_q;
    row_keys     = count_low(col_s2_q);
    tot_keys     = {1'b0, acc_cnt_q} + row_keys;
    acc_sum      = (tot_keys >= 3'd2) ? 2'd2 : tot_keys[1:0];
    acc_code_new = (acc_cnt_q == 2'd0 && row_keys != 3'd0) ?
                   {row_idx, first_low(col_s2_q)} : acc_code_q;
    case (acc_sum)
      2'd0:    fclass = FC_NONE;
      2'd1:    fclass = FC_ONE;
      default: fclass = FC_MULTI;
    endcase

    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (frame_end) begin
      acc_cnt_d  = 2'd0;
      acc_code_d = 4'd0;
    end else if (sample) begin
      acc_cnt_d  = acc_sum;
      acc_code_d = acc_code_new;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cand_d        = cand_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (fclass == FC_ONE) begin
            cand_d = acc_code_new;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d       = HELD;
              key_code_d    = acc_code_new;
              key_valid_d   = 1'b1;
              key_pressed_d = 1'b1;
              cnt_d         = '0;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = DW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (fclass == FC_ONE && acc_code_new == cand_q) begin
            if (cnt_q + DW'(1) == DW'(DEBOUNCE_FRAMES)) begin
              state_d       = HELD;
              key_code_d    = cand_q;
              key_valid_d   = 1'b1;
              key_pressed_d = 1'b1;
              cnt_d         = '0;
            end else begin
              cnt_d = cnt_q + DW'(1);
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (fclass == FC_NONE) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d       = IDLE;
              key_pressed_d = 1'b0;
              cnt_d         = '0;
            end else begin
              state_d = RELEASE;
              cnt_d   = DW'(1);
            end
          end
        end
        default: begin
          if (fclass == FC_NONE) begin
            if (cnt_q + DW'(1) == DW'(DEBOUNCE_FRAMES)) begin
              state_d       = IDLE;
              key_pressed_d = 1'b0;
              cnt_d         = '0;
            end else begin
              cnt_d = cnt_q + DW'(1);
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_s1_q      <= 4'hF;
      col_s2_q      <= 4'hF;
      acc_cnt_q     <= 2'd0;
      acc_code_q    <= 4'd0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      cand_q        <= 4'd0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      col_s1_q      <= col_s1_d;
      col_s2_q      <= col_s2_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_code_q    <= acc_code_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cand_q        <= cand_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a frame-level model of the keypad debounce rules
// checked every cycle, plus hand-computed expectations per scenario.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DF = 3;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] press_mask = '0;

  keypad_scan_if kp();

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk  (clk),
    .rstn (rstn),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its column low while its row is strobed.
  always_comb begin
    kp.col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!kp.row[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (press_mask[r*4+c]) kp.col[c] = 1'b0;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: counts pressed keys per frame in scan order and
  // applies the run-length press/release rules.
  int         m_edges, m_keys, m_first, m_streak, m_cand;
  bit         m_held, m_valid, m_pressed;
  logic [3:0] m_code;
  int         t_keys, t_first, t_strk, t_cand, t_r;
  bit         t_held;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_edges <= 0; m_keys <= 0; m_first <= -1; m_streak <= 0; m_cand <= 0;
      m_held <= 0; m_valid <= 0; m_pressed <= 0; m_code <= 4'h0;
    end else begin
      m_valid <= 0;
      t_keys  = m_keys;
      t_first = m_first;
      if (m_edges % SD == SD - 1) begin
        t_r = (m_edges / SD) % 4;
        for (int c = 0; c < 4; c++) begin
          if (press_mask[t_r*4+c]) begin
            if (t_first < 0) t_first = t_r * 4 + c;
            t_keys++;
          end
        end
      end
      if (m_edges % FR == FR - 1) begin
        t_strk = m_streak; t_cand = m_cand; t_held = m_held;
        if (!t_held) begin
          if (t_keys == 1 && (t_strk == 0 || t_first == t_cand)) begin
            if (t_strk == 0) t_cand = t_first;
            t_strk++;
          end else begin
            t_strk = 0;
          end
          if (t_strk == DF) begin
            t_held = 1; t_strk = 0;
            m_valid <= 1;
            m_code  <= 4'(t_cand);
          end
        end else begin
          if (t_keys == 0) t_strk++;
          else t_strk = 0;
          if (t_strk == DF) begin
            t_held = 0; t_strk = 0;
          end
        end
        m_streak  <= t_strk;
        m_cand    <= t_cand;
        m_held    <= t_held;
        m_pressed <= t_held;
        m_keys    <= 0;
        m_first   <= -1;
      end else begin
        m_keys  <= t_keys;
        m_first <= t_first;
      end
      m_edges <= m_edges + 1;
    end
  end

  function automatic logic [3:0] exp_row(input int e);
    logic [3:0] v;
    v = 4'hF;
    v[(e / SD) % 4] = 1'b0;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      check("row", kp.row, exp_row(m_edges));
      check("key_valid", {3'b0, kp.key_valid}, {3'b0, m_valid});
      check("key_pressed", {3'b0, kp.key_pressed}, {3'b0, m_pressed});
      check("key_code", kp.key_code, m_code);
    end
  end

  int pulses = 0;
  int pulse_at = -1;
  always @(negedge clk) begin
    if (rstn && kp.key_valid) begin
      pulses++;
      pulse_at = m_edges;
    end
  end

  function automatic logic [15:0] key(input int r, input int c);
    return 16'd1 << (r * 4 + c);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int p0;

  initial begin
    rstn = 1'b0;
    press_mask = '0;
    cyc(3);
    rstn = 1'b1;

    // Idle scan, no keys
    check("s1_row_c0", kp.row, 4'b1110);
    cyc(4);  check("s1_row_c4", kp.row, 4'b1101);
    cyc(4);  check("s1_row_c8", kp.row, 4'b1011);
    cyc(4);  check("s1_row_c12", kp.row, 4'b0111);
    cyc(4);  check("s1_row_c16", kp.row, 4'b1110);
    cyc(16);
    check_int("s1_pulses", pulses, 0);
    check("s1_code", kp.key_code, 4'h0);
    check("s1_pressed", {3'b0, kp.key_pressed}, 4'h0);

    // Steady press of (2,1) from edge 32: accepted after 3rd frame end (edge 79)
    p0 = pulses;
    press_mask = key(2, 1);
    cyc(80);
    check_int("s2_pulses", pulses - p0, 1);
    check_int("s2_pulse_at", pulse_at, 80);
    check("s2_code", kp.key_code, 4'h9);
    check("s2_pressed", {3'b0, kp.key_pressed}, 4'h1);

    // Release bounce keeps the key held
    press_mask = '0;     cyc(32);
    press_mask = key(2, 1); cyc(16);
    check("s5_bounce_pressed", {3'b0, kp.key_pressed}, 4'h1);
    check_int("s5_bounce_pulses", pulses - p0, 1);
    press_mask = '0;
    cyc(47);
    check("s5_pressed_before_rel", {3'b0, kp.key_pressed}, 4'h1);
    cyc(1);
    check("s5_pressed_after_rel", {3'b0, kp.key_pressed}, 4'h0);
    p0 = pulses;
    press_mask = key(0, 3);
    cyc(64);
    check_int("s5_new_pulses", pulses - p0, 1);
    check_int("s5_new_pulse_at", pulse_at, 256);
    check("s5_new_code", kp.key_code, 4'h3);
    press_mask = '0;
    cyc(48);
    check("s5_final_release", {3'b0, kp.key_pressed}, 4'h0);

    // Bouncy press never reaches three clean frames
    p0 = pulses;
    press_mask = key(1, 2); cyc(16);
    press_mask = '0;        cyc(16);
    press_mask = key(1, 2); cyc(32);
    press_mask = '0;        cyc(32);
    check_int("s3_pulses", pulses - p0, 0);
    check("s3_pressed", {3'b0, kp.key_pressed}, 4'h0);
    check("s3_code_held", kp.key_code, 4'h3);

    // Two keys together form MULTI frames only
    press_mask = key(0, 0) | key(3, 3);
    cyc(96);
    check_int("s4_pulses", pulses - p0, 0);
    check("s4_pressed", {3'b0, kp.key_pressed}, 4'h0);
    press_mask = '0;
    cyc(16);

    // Reset during debounce (cnt=2) aborts; a fresh 3 frames are needed
    press_mask = key(1, 1);
    cyc(32);
    cyc(5);
    rstn = 1'b0;
    #1;
    check("s6_rst_row", kp.row, 4'b1110);
    check("s6_rst_code", kp.key_code, 4'h0);
    check("s6_rst_valid", {3'b0, kp.key_valid}, 4'h0);
    check("s6_rst_pressed", {3'b0, kp.key_pressed}, 4'h0);
    cyc(2);
    rstn = 1'b1;
    p0 = pulses;
    cyc(47);
    check_int("s6_no_early_pulse", pulses - p0, 0);
    cyc(1);
    check_int("s6_pulses", pulses - p0, 1);
    check_int("s6_pulse_at", pulse_at, 48);
    check("s6_valid_hi", {3'b0, kp.key_valid}, 4'h1);
    check("s6_code", kp.key_code, 4'h5);
    cyc(1);
    check("s6_valid_lo", {3'b0, kp.key_valid}, 4'h0);
    check("s6_pressed", {3'b0, kp.key_pressed}, 4'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
